// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
//   Shared definitions for the ram_axi_slave controller:
//     - state_e       : controller FSM states
//     - RESP_OKAY /
//       RESP_SLVERR   : AXI response codes
//     - strb_to_mask  : expand an 8-bit byte strobe into a 64-bit bit mask
//     - addr_in_range : window check of a byte address against a base and a
//                       power-of-two size
// -----------------------------------------------------------------------------
package axi_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_ACK  = 3'd4,
        ST_WR_RESP = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte k of the mask is all-ones when strobe bit k is set.
    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int k = 0; k < 8; k++) begin
            mask[k*8 +: 8] = {8{strb[k]}};
        end
        return mask;
    endfunction

    // The offset is a plain 32-bit unsigned difference, so an address below
    // the base wraps to a huge offset and is rejected.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned size_log2
    );
        logic [31:0] offset;
        offset = addr - base;
        if (size_log2 >= 32) begin
            return 1'b1;
        end
        return (offset >> size_log2) == 32'd0;
    endfunction

endpackage

// File: rtl/ram_axi_slave.sv
// -----------------------------------------------------------------------------
// ram_axi_slave
//   AXI4-Lite-style slave in front of the flat-port `ram` block. One
//   transaction is in flight at a time; a complete write (AW + W) wins over a
//   read presented in the same cycle. Byte strobes are expanded to a 64-bit
//   bit mask and addresses are checked against [BASE_ADDR, BASE_ADDR+2^SIZE_LOG2).
//
// Parameters
//   BASE_ADDR  first byte address backed by ram
//   SIZE_LOG2  log2 of the ram byte capacity
//
// Ports
//   clk, rst                       clock; asynchronous active-low reset
//   araddr_i/arvalid_i/arready_o   read address channel
//   rdata_o/rresp_o/rvalid_o/rready_i  read data channel
//   awaddr_i/awvalid_i/awready_o   write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o  write data channel
//   bresp_o/bvalid_o/bready_i      write response channel
//   ram_raddr_o/ram_ren_o/ram_rdata_i  ram read port (combinational data)
//   ram_waddr_o/ram_wdata_o/ram_wmask_o/ram_wen_o  ram write port
//   ram_bvalid_i                   ram write-complete pulse
// -----------------------------------------------------------------------------
module ram_axi_slave
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned SIZE_LOG2 = 23
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] araddr_i,
    input  logic        arvalid_i,
    output logic        arready_o,

    output logic [63:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rvalid_o,
    input  logic        rready_i,

    input  logic [31:0] awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,

    input  logic [63:0] wdata_i,
    input  logic [7:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,

    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,

    output logic [31:0] ram_raddr_o,
    output logic        ram_ren_o,
    input  logic [63:0] ram_rdata_i,

    output logic [31:0] ram_waddr_o,
    output logic [63:0] ram_wdata_o,
    output logic [63:0] ram_wmask_o,
    output logic        ram_wen_o,
    input  logic        ram_bvalid_i
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e      state_q,   state_d;
    logic        run_q,     run_d;      // low during reset and the first cycle after
    logic        aw_held_q, aw_held_d;
    logic        w_held_q,  w_held_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [63:0] w_data_q,  w_data_d;
    logic [7:0]  w_strb_q,  w_strb_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [63:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;
    logic        rvalid_q,  rvalid_d;
    logic [1:0]  bresp_q,   bresp_d;
    logic        bvalid_q,  bvalid_d;
    logic        ram_ren_q, ram_ren_d;
    logic        ram_wen_q, ram_wen_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic        in_idle;
    logic        awready_c;
    logic        wready_c;
    logic        arready_c;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic [31:0] wr_addr_eff;
    logic        rd_in_range;
    logic        wr_in_range;

    // Ready outputs are held low while in reset (and for the first cycle
    // after release) so that every output reads zero during reset.
    assign in_idle   = (state_q == ST_IDLE) && run_q;
    assign awready_c = in_idle && !aw_held_q;
    assign wready_c  = in_idle && !w_held_q;
    assign aw_hs     = awvalid_i && awready_c;
    assign w_hs      = wvalid_i && wready_c;

    // A read is only offered when no write is partially or newly captured,
    // which gives writes priority and keeps the AR retry clean.
    assign arready_c = in_idle && !aw_held_q && !w_held_q && !aw_hs && !w_hs;
    assign ar_hs     = arvalid_i && arready_c;

    // Address of the write about to start: fresh from the bus if AW is
    // handshaking this cycle, otherwise from the holding register.
    assign wr_addr_eff = aw_hs ? awaddr_i : aw_addr_q;

    assign rd_in_range = addr_in_range(ar_addr_q, BASE_ADDR, SIZE_LOG2);
    assign wr_in_range = addr_in_range(aw_addr_q, BASE_ADDR, SIZE_LOG2);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        run_d     = 1'b1;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        ar_addr_d = ar_addr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rvalid_d  = rvalid_q;
        bresp_d   = bresp_q;
        bvalid_d  = bvalid_q;
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    aw_addr_d = awaddr_i;
                    aw_held_d = 1'b1;
                end
                if (w_hs) begin
                    w_data_d = wdata_i;
                    w_strb_d = wstrb_i;
                    w_held_d = 1'b1;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    // ram_wen is registered so it lines up with WR_REQ.
                    state_d   = ST_WR_REQ;
                    ram_wen_d = addr_in_range(wr_addr_eff, BASE_ADDR, SIZE_LOG2);
                end else if (ar_hs) begin
                    ar_addr_d = araddr_i;
                    ram_ren_d = addr_in_range(araddr_i, BASE_ADDR, SIZE_LOG2);
                    state_d   = ST_RD_REQ;
                end
            end

            ST_RD_REQ: begin
                // ram read data is combinational on ram_raddr_o; capture it
                // here so rdata_o stays stable for the whole response phase.
                if (rd_in_range) begin
                    rdata_d = ram_rdata_i;
                    rresp_d = RESP_OKAY;
                end else begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
                rvalid_d = 1'b1;
                state_d  = ST_RD_RESP;
            end

            ST_RD_RESP: begin
                if (rready_i) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            ST_WR_REQ: begin
                if (wr_in_range) begin
                    state_d = ST_WR_ACK;
                end else begin
                    bresp_d   = RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    state_d   = ST_WR_RESP;
                end
            end

            ST_WR_ACK: begin
                if (ram_bvalid_i) begin
                    bresp_d   = RESP_OKAY;
                    bvalid_d  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    state_d   = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (bready_i) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            ar_addr_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bvalid_q  <= 1'b0;
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            ar_addr_q <= ar_addr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            bvalid_q  <= bvalid_d;
            ram_ren_q <= ram_ren_d;
            ram_wen_q <= ram_wen_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign arready_o   = arready_c;
    assign awready_o   = awready_c;
    assign wready_o    = wready_c;

    assign rdata_o     = rdata_q;
    assign rresp_o     = rresp_q;
    assign rvalid_o    = rvalid_q;
    assign bresp_o     = bresp_q;
    assign bvalid_o    = bvalid_q;

    assign ram_raddr_o = ar_addr_q;
    assign ram_ren_o   = ram_ren_q;
    assign ram_waddr_o = aw_addr_q;
    assign ram_wmask_o = strb_to_mask(w_strb_q);
    // ram ORs write data into the old word, so disabled bytes must be zero.
    assign ram_wdata_o = w_data_q & ram_wmask_o;
    assign ram_wen_o   = ram_wen_q;

endmodule
